// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
//
// Feeds the VGA output stage with upscaled 1-bit pixels read from a
// double-buffered frame memory. Each memory word holds WORD_W pixels,
// MSB = leftmost. Every stored pixel is repeated SCALE times along a line,
// and every stored row is repeated for SCALE lines. The memory image is
// H_AREA/SCALE x V_AREA/SCALE pixels.
//
// Optional feature macro: LINE_CHECK_EN. When it is defined, line_err flags
// lines whose active length is not H_AREA, and any active outside RUN.
// When it is undefined, line_err is tied low.
//
// Ports
//   CLK_40      in   pixel clock
//   reset       in   asynchronous, active-high
//   active      in   VGA visible-pixel strobe
//   frame_ready in   loader has a finished frame in bank ~bank_sel
//   rd_data     in   memory read data, valid 1 cycle after rd_en
//   rd_en       out  memory read strobe
//   rd_addr     out  {bank_sel, word offset}
//   bank_sel    out  bank being displayed
//   frame_ack   out  one-cycle pulse on a buffer swap
//   count_en    out  raster enable for the VGA stage (high in RUN)
//   pixel_color out  1 = white, zero-cycle relative to active
//   line_err    out  sticky line-length / stray-active error
module frame_pixel_streamer #(
  parameter int H_AREA        = 800,
  parameter int V_AREA        = 600,
  parameter int SCALE         = 4,
  parameter int WORD_W        = 8,
  // Derived; not meant to be overridden.
  parameter int WORDS_PER_ROW = H_AREA / (SCALE * WORD_W),
  parameter int ADDR_W        = $clog2(WORDS_PER_ROW * V_AREA / SCALE) + 1
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              active,
  input  logic              frame_ready,
  input  logic [WORD_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              bank_sel,
  output logic              frame_ack,
  output logic              count_en,
  output logic              pixel_color,
  output logic              line_err
);

  localparam int ROWS  = V_AREA / SCALE;
  localparam int OFF_W = ADDR_W - 1;
  localparam int PX_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t            state, state_nx;
  logic [1:0]        pf;          // prefetch phase: 1 = word 0, 2 = word 1, 3 = last return
  logic              active_d;
  logic [PX_W-1:0]   px_rep;
  logic [BIT_W-1:0]  bit_idx;
  logic [PX_W-1:0]   ln_rep;
  logic [ROW_W-1:0]  row;
  logic [OFF_W-1:0]  row_base;
  logic [OFF_W-1:0]  word_ptr;    // offset of the most recently fetched word
  logic [OFF_W-1:0]  rd_off;
  logic              rd_to_shift;
  logic              rd_pend_p0;
  logic              rd_to_shift_p0;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] hold;

  logic run, act_run, px_last, bit_last, ln_last, row_last;
  logic wrap, more_words, line_end, frame_end, start_prime, swap;
  logic pf_rd0, pf_rd1, wrap_rd;

  assign run         = (state == RUN);
  assign act_run     = active & run;
  assign px_last     = (px_rep == PX_W'(SCALE - 1));
  assign bit_last    = (bit_idx == BIT_W'(WORD_W - 1));
  assign ln_last     = (ln_rep == PX_W'(SCALE - 1));
  assign row_last    = (row == ROW_W'(ROWS - 1));
  assign wrap        = act_run & px_last & bit_last;
  // The last word of a row has nothing after it to prefetch.
  assign more_words  = ({1'b0, word_ptr} + (OFF_W + 1)'(1)) <
                       ({1'b0, row_base} + (OFF_W + 1)'(WORDS_PER_ROW));
  assign line_end    = run & active_d & ~active;
  assign frame_end   = line_end & ln_last & row_last;
  assign start_prime = (state == IDLE) & frame_ready;
  assign swap        = start_prime | (frame_end & frame_ready);
  assign pf_rd0      = (pf == 2'd1);
  // PRIME always reads two words; a line-end prefetch skips word 1 when a row is one word.
  assign pf_rd1      = (pf == 2'd2) & ((state == PRIME) | (WORDS_PER_ROW > 1));
  assign wrap_rd     = wrap & more_words;

  always_comb begin
    state_nx    = state;
    count_en    = 1'b0;
    rd_en       = 1'b0;
    rd_off      = '0;
    rd_to_shift = 1'b0;
    case (state)
      IDLE:    if (frame_ready) state_nx = PRIME;
      PRIME:   if (pf == 2'd3) state_nx = RUN;
      RUN:     count_en = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (pf_rd0) begin
      rd_en       = 1'b1;
      rd_off      = row_base;
      rd_to_shift = 1'b1;
    end else if (pf_rd1) begin
      rd_en  = 1'b1;
      rd_off = row_base + OFF_W'(1);
    end else if (wrap_rd) begin
      rd_en  = 1'b1;
      rd_off = word_ptr + OFF_W'(1);
    end
  end

  assign rd_addr     = rd_en ? {bank_sel, rd_off} : '0;
  assign pixel_color = act_run & shift[WORD_W-1];

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pf             <= 2'd0;
      active_d       <= 1'b0;
      px_rep         <= '0;
      bit_idx        <= '0;
      ln_rep         <= '0;
      row            <= '0;
      row_base       <= '0;
      word_ptr       <= '0;
      bank_sel       <= 1'b0;
      frame_ack      <= 1'b0;
      rd_pend_p0     <= 1'b0;
      rd_to_shift_p0 <= 1'b0;
    end else begin
      state          <= state_nx;
      active_d       <= act_run;
      frame_ack      <= swap;
      bank_sel       <= bank_sel ^ swap;
      rd_pend_p0     <= rd_en;
      rd_to_shift_p0 <= rd_to_shift;

      if (start_prime || line_end) pf <= 2'd1;
      else if (pf != 2'd0)         pf <= pf + 2'd1;

      if (pf_rd0)       word_ptr <= row_base;
      else if (pf_rd1)  word_ptr <= row_base + OFF_W'(1);
      else if (wrap_rd) word_ptr <= word_ptr + OFF_W'(1);

      if (line_end) begin
        px_rep  <= '0;
        bit_idx <= '0;
        if (ln_last) begin
          ln_rep <= '0;
          if (row_last) begin
            row      <= '0;
            row_base <= '0;
          end else begin
            row      <= row + ROW_W'(1);
            row_base <= row_base + OFF_W'(WORDS_PER_ROW);
          end
        end else begin
          ln_rep <= ln_rep + PX_W'(1);
        end
      end else if (act_run) begin
        px_rep <= px_last ? '0 : px_rep + PX_W'(1);
        if (px_last) bit_idx <= bit_last ? '0 : bit_idx + BIT_W'(1);
      end
    end
  end

  // ---- p0 -> data: read returns land one cycle after the strobe ----
  always_ff @(posedge CLK_40) begin
    if (rd_pend_p0 && rd_to_shift_p0) shift <= rd_data;
    else if (wrap)                    shift <= hold;
    else if (act_run && px_last)      shift <= shift << 1;
    if (rd_pend_p0 && !rd_to_shift_p0) hold <= rd_data;
  end

`ifdef LINE_CHECK_EN
  localparam int CNT_W = $clog2(H_AREA + 2);
  logic [CNT_W-1:0] px_cnt;
  logic             line_err_r;

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      px_cnt     <= '0;
      line_err_r <= 1'b0;
    end else begin
      if (line_end) begin
        px_cnt <= '0;
        if (px_cnt != CNT_W'(H_AREA)) line_err_r <= 1'b1;
      end else if (act_run && px_cnt != CNT_W'(H_AREA + 1)) begin
        px_cnt <= px_cnt + CNT_W'(1);   // saturates one past H_AREA
      end
      if (active && !run) line_err_r <= 1'b1;
    end
  end

  assign line_err = line_err_r;
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_pixel_streamer.sv
module tb_frame_pixel_streamer;
  localparam int H  = 32;
  localparam int V  = 24;
  localparam int S  = 4;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          CLK_40 = 1'b0;
  logic          reset;
  logic          active;
  logic          frame_ready;
  logic [W-1:0]  rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          bank_sel;
  logic          frame_ack;
  logic          count_en;
  logic          pixel_color;
  logic          line_err;

  int   total = 0;
  int   bad   = 0;
  logic exp_bank;
  logic exp_lerr;
  logic [W-1:0] mem [16];

  frame_pixel_streamer #(.H_AREA(H), .V_AREA(V), .SCALE(S), .WORD_W(W)) dut (
    .CLK_40(CLK_40), .reset(reset), .active(active), .frame_ready(frame_ready),
    .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr), .bank_sel(bank_sel),
    .frame_ack(frame_ack), .count_en(count_en), .pixel_color(pixel_color),
    .line_err(line_err)
  );

  always #5 CLK_40 = ~CLK_40;

  // Frame memory with one cycle of read latency.
  always @(posedge CLK_40) if (rd_en) rd_data <= mem[rd_addr];

  // One clock: inputs for the new cycle are applied just after the edge.
  task automatic cyc(input logic act, input logic fr);
    @(posedge CLK_40);
    #1;
    active      = act;
    frame_ready = fr;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; active = 1'b0; frame_ready = 1'b0;
    cyc(0, 0); cyc(0, 0);
    total++; if (rd_en !== 1'b0)       begin bad++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
    total++; if (rd_addr !== 4'h0)     begin bad++; $display("FAIL reset_rd_addr got=%0h exp=0", rd_addr); end
    total++; if (bank_sel !== 1'b0)    begin bad++; $display("FAIL reset_bank_sel got=%0b exp=0", bank_sel); end
    total++; if (frame_ack !== 1'b0)   begin bad++; $display("FAIL reset_frame_ack got=%0b exp=0", frame_ack); end
    total++; if (count_en !== 1'b0)    begin bad++; $display("FAIL reset_count_en got=%0b exp=0", count_en); end
    total++; if (pixel_color !== 1'b0) begin bad++; $display("FAIL reset_pixel_color got=%0b exp=0", pixel_color); end
    total++; if (line_err !== 1'b0)    begin bad++; $display("FAIL reset_line_err got=%0b exp=0", line_err); end
    @(negedge CLK_40);
    reset = 1'b0;
  endtask

  // frame_ready is held for one cycle; the swap starts PRIME.
  task automatic test_prime;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      total++; if (count_en !== 1'b0) begin bad++; $display("FAIL idle_count_en got=%0b exp=0", count_en); end
    end
    cyc(0, 1);
    total++; if (frame_ack !== 1'b0) begin bad++; $display("FAIL prime_ack_early got=%0b exp=0", frame_ack); end
    cyc(0, 0);
    total++; if (frame_ack !== 1'b1)  begin bad++; $display("FAIL prime_ack got=%0b exp=1", frame_ack); end
    total++; if (bank_sel !== 1'b1)   begin bad++; $display("FAIL prime_bank got=%0b exp=1", bank_sel); end
    total++; if (rd_en !== 1'b1 || rd_addr !== 4'b1000) begin bad++; $display("FAIL prime_rd0 got=%0b/%0h exp=1/8", rd_en, rd_addr); end
    total++; if (count_en !== 1'b0)   begin bad++; $display("FAIL prime_count_en0 got=%0b exp=0", count_en); end
    cyc(0, 0);
    total++; if (frame_ack !== 1'b0)  begin bad++; $display("FAIL prime_ack_pulse got=%0b exp=0", frame_ack); end
    total++; if (rd_en !== 1'b1 || rd_addr !== 4'b1001) begin bad++; $display("FAIL prime_rd1 got=%0b/%0h exp=1/9", rd_en, rd_addr); end
    cyc(0, 0);
    total++; if (rd_en !== 1'b0)      begin bad++; $display("FAIL prime_rd_idle got=%0b exp=0", rd_en); end
    total++; if (count_en !== 1'b0)   begin bad++; $display("FAIL prime_count_en2 got=%0b exp=0", count_en); end
    cyc(0, 0);
    total++; if (count_en !== 1'b1)   begin bad++; $display("FAIL prime_run got=%0b exp=1", count_en); end
    exp_bank = 1'b1;
  endtask

  // One raster line of nact active cycles followed by 4 blanking cycles.
  task automatic do_line(input int line, input int nact, input logic fr_end,
                         input logic chk, input logic use_pat, input logic [31:0] pat);
    logic [W-1:0] word;
    logic         exp_px;
    logic         fe;
    int           next_row;
    word = mem[{exp_bank, 3'(line / S)}];
    for (int i = 0; i < nact; i++) begin
      cyc(1, 0);
      exp_px = use_pat ? pat[31 - i] : word[W - 1 - (i / S)];
      if (chk) begin
        total++; if (pixel_color !== exp_px) begin bad++; $display("FAIL pixel line=%0d px=%0d got=%0b exp=%0b", line, i, pixel_color, exp_px); end
      end
    end
    if (chk) begin
      total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL line_no_read line=%0d got=%0b exp=0", line, rd_en); end
    end
    cyc(0, fr_end);
    total++; if (pixel_color !== 1'b0) begin bad++; $display("FAIL blank_pixel line=%0d got=%0b exp=0", line, pixel_color); end
    fe = (line == V - 1);
    if (fe && fr_end) exp_bank = ~exp_bank;
    next_row = fe ? 0 : (line + 1) / S;
    cyc(0, 0);
    total++; if (frame_ack !== (fe & fr_end)) begin bad++; $display("FAIL line_ack line=%0d got=%0b exp=%0b", line, frame_ack, fe & fr_end); end
    total++; if (bank_sel !== exp_bank) begin bad++; $display("FAIL line_bank line=%0d got=%0b exp=%0b", line, bank_sel, exp_bank); end
    total++; if (rd_en !== 1'b1 || rd_addr !== {exp_bank, 3'(next_row)}) begin
      bad++; $display("FAIL line_prefetch line=%0d got=%0b/%0h exp=1/%0h", line, rd_en, rd_addr, {exp_bank, 3'(next_row)});
    end
    cyc(0, 0);
    cyc(0, 0);
  endtask

  task automatic test_first_frame;
    do_line(0, H, 0, 1, 1, 32'b1111_0000_1111_0000_0000_1111_0000_1111);
    for (int l = 1; l < V; l++) do_line(l, H, 0, 1, 0, 32'h0);
  endtask

  task automatic test_repeat_and_swap;
    for (int l = 0; l < V - 1; l++) do_line(l, H, 0, 1, 0, 32'h0);
    do_line(V - 1, H, 1, 1, 0, 32'h0);
  endtask

  task automatic test_mid_reset;
    for (int l = 0; l < 10; l++) do_line(l, H, 0, 1, 0, 32'h0);
    for (int i = 0; i < 13; i++) cyc(1, 0);
    total++; if (pixel_color !== 1'b1) begin bad++; $display("FAIL pre_reset_pixel got=%0b exp=1", pixel_color); end
    reset = 1'b1;
    #1;
    total++; if (count_en !== 1'b0)    begin bad++; $display("FAIL midrst_count_en got=%0b exp=0", count_en); end
    total++; if (pixel_color !== 1'b0) begin bad++; $display("FAIL midrst_pixel got=%0b exp=0", pixel_color); end
    total++; if (rd_en !== 1'b0 || rd_addr !== 4'h0) begin bad++; $display("FAIL midrst_rd got=%0b/%0h exp=0/0", rd_en, rd_addr); end
    total++; if (bank_sel !== 1'b0 || frame_ack !== 1'b0) begin bad++; $display("FAIL midrst_bank_ack got=%0b/%0b exp=0/0", bank_sel, frame_ack); end
    total++; if (line_err !== 1'b0)    begin bad++; $display("FAIL midrst_line_err got=%0b exp=0", line_err); end
    active = 1'b0;
    cyc(0, 0);
    @(negedge CLK_40);
    reset = 1'b0;
    cyc(0, 0);
    total++; if (count_en !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%0b exp=0", count_en); end
  endtask

  task automatic test_line_check;
    cyc(0, 1);
    cyc(0, 0);
    exp_bank = 1'b1;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    total++; if (count_en !== 1'b1) begin bad++; $display("FAIL reprime_run got=%0b exp=1", count_en); end
    do_line(0, H - 1, 0, 1, 0, 32'h0);
    total++; if (line_err !== exp_lerr) begin bad++; $display("FAIL short_line_err got=%0b exp=%0b", line_err, exp_lerr); end
    do_line(1, H, 0, 1, 0, 32'h0);
    total++; if (line_err !== exp_lerr) begin bad++; $display("FAIL line_err_sticky got=%0b exp=%0b", line_err, exp_lerr); end
  endtask

  initial begin
`ifdef LINE_CHECK_EN
    exp_lerr = 1'b1;
`else
    exp_lerr = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[8]  = 8'hA5; mem[9]  = 8'h3C; mem[10] = 8'h81;
    mem[11] = 8'h7E; mem[12] = 8'h0F; mem[13] = 8'hC3;
    mem[0]  = 8'hFF; mem[1]  = 8'h81; mem[2]  = 8'hF0;
    mem[3]  = 8'h55; mem[4]  = 8'h00; mem[5]  = 8'hAA;
    exp_bank = 1'b0;
    test_reset;
    test_prime;
    test_first_frame;
    test_repeat_and_swap;
    test_mid_reset;
    test_line_check;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
